// File: rtl/io_terminal_port.sv
// ---------------------------------------------------------------------------
// io_terminal_port
//
// Device-side terminal port for the basic computer. Holds the input register
// (INPR) with its flag FGI and the output register (OUTR) with its flag FGO,
// accepts bytes from an input device and presents bytes to an output device,
// executes the CPU side of INP/OUT and raises irq for the controller's R
// flip-flop.
//
// Parameters
//   DATA_W  width of INPR, OUTR and both device data paths
//   TX_GAP  cycles the output device stays busy after each tx handshake
//           before FGO re-asserts (0 allowed)
//
// Ports
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   inp_rd    INP executed: CPU takes inpr this cycle, clears FGI
//   inpr      input register
//   fgi       input flag, 1 = inpr holds an unread byte
//   out_wr    OUT executed: out_data -> OUTR, clears FGO
//   out_data  byte from AC
//   fgo       output flag, 1 = port ready for the next OUT
//   ien       interrupt enable from the controller
//   irq       interrupt request, ien & (fgi | fgo)
//   rx_valid  input device offers rx_data
//   rx_data   input device byte
//   rx_ready  port can accept an input byte (= ~fgi)
//   tx_valid  port offers tx_data to the output device
//   tx_data   byte to the output device (= OUTR)
//   tx_ready  output device accepts tx_data
//   tx_drop   sticky: an out_wr arrived while FGO was low and was ignored
// ---------------------------------------------------------------------------
module io_terminal_port #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TX_GAP = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inp_rd,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    output logic              fgo,
    input  logic              ien,
    output logic              irq,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              tx_drop
);

    // Gap counter is loaded with TX_GAP-1 and only counts down to zero.
    localparam int unsigned CNT_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (TX_GAP == 0) ? '0 : CNT_W'(TX_GAP - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP_WAIT
    } tx_state_e;

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] inpr_q;
    logic              fgi_q;

    // While FGI is set the device is stalled (rx_ready low), so a read and an
    // offered byte in the same cycle only clear the flag; the byte lands on a
    // later edge. This makes overrun impossible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inpr_q <= '0;
            fgi_q  <= 1'b0;
        end else if (fgi_q) begin
            if (inp_rd) begin
                fgi_q <= 1'b0;
            end
        end else if (rx_valid) begin
            inpr_q <= rx_data;
            fgi_q  <= 1'b1;
        end
    end

    assign inpr     = inpr_q;
    assign fgi      = fgi_q;
    assign rx_ready = ~fgi_q;

    // ------------------------------------------------------------------
    // Output path FSM
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q;
    logic [DATA_W-1:0] outr_q;
    logic              fgo_q;
    logic              tx_valid_q;
    logic              tx_drop_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            outr_q     <= '0;
            fgo_q      <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_drop_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (out_wr) begin
                        outr_q     <= out_data;
                        fgo_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_state_q <= TX_SEND;
                    end
                end

                TX_SEND: begin
                    // An OUT while busy is discarded; the in-flight byte keeps
                    // going and the event is recorded in the sticky flag.
                    if (out_wr) begin
                        tx_drop_q <= 1'b1;
                    end
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (TX_GAP == 0) begin
                            fgo_q      <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            cnt_q      <= GAP_LOAD;
                            tx_state_q <= TX_GAP_WAIT;
                        end
                    end
                end

                TX_GAP_WAIT: begin
                    if (out_wr) begin
                        tx_drop_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        fgo_q      <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    fgo_q      <= 1'b1;
                    tx_valid_q <= 1'b0;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign fgo      = fgo_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = outr_q;
    assign tx_drop  = tx_drop_q;

    // Combinational so that irq follows ien within the same cycle.
    assign irq = ien & (fgi_q | fgo_q);

endmodule
